// File: rtl/enums_pkg.sv
// Shared enumerations for the data-memory responder and its neighbours:
// access size/signedness, responder FSM state, and small request-decode helpers.
package enums_pkg;

  // Access size; encodings 5..7 are illegal and flagged as errors.
  typedef enum logic [2:0] {
    MEM_BYTE  = 3'd0,
    MEM_HALF  = 3'd1,
    MEM_WORD  = 3'd2,
    MEM_BYTEU = 3'd3,
    MEM_HALFU = 3'd4
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  function automatic logic size_is_legal(input mem_size_t size);
    return (3'(size) <= 3'd4);
  endfunction

  function automatic logic addr_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
    case (size)
      MEM_HALF, MEM_HALFU: return addr_lo[0];
      MEM_WORD:            return |addr_lo;
      default:             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between a load/store initiator and the data-memory responder.
interface dmem_responder_if;
  import enums_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  mem_size_t   req_size;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: extracts and extends load data from a word,
// and produces byte enables plus lane-replicated store data.
module dmem_lane_align
  import enums_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  mem_size_t   size,
  input  logic [31:0] word,
  output logic [31:0] rdata,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_rep
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane(s) and decode enables/extension by access size.
  always_comb begin
    byte_sel  = word[{addr_lo, 3'b000} +: 8];
    half_sel  = word[{addr_lo[1], 4'b0000} +: 16];
    rdata     = '0;
    byte_en   = '0;
    wdata_rep = '0;
    case (size)
      MEM_BYTE: begin
        rdata     = {{24{byte_sel[7]}}, byte_sel};
        byte_en   = 4'b0001 << addr_lo;
        wdata_rep = {4{word[7:0]}};
      end
      MEM_BYTEU: begin
        rdata     = {24'd0, byte_sel};
        byte_en   = 4'b0001 << addr_lo;
        wdata_rep = {4{word[7:0]}};
      end
      MEM_HALF: begin
        rdata     = {{16{half_sel[15]}}, half_sel};
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{word[15:0]}};
      end
      MEM_HALFU: begin
        rdata     = {16'd0, half_sel};
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{word[15:0]}};
      end
      MEM_WORD: begin
        rdata     = word;
        byte_en   = 4'b1111;
        wdata_rep = word;
      end
      default: begin
        rdata     = '0;
        byte_en   = '0;
        wdata_rep = '0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with a fixed number of wait states.
// The access (store commit or load read) happens on the edge that enters RESP;
// the response is then held until the initiator takes it.
module dmem_responder
  import enums_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input logic            clk,
  input logic            rst,
  dmem_responder_if.slave bus
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_LOAD  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

  dmem_state_t state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        accept;
  logic        commit;

  logic        we_q;
  logic [31:0] addr_q;
  mem_size_t   size_q;
  logic [31:0] wdata_q;

  logic        cur_we;
  logic [31:0] cur_addr;
  mem_size_t   cur_size;
  logic [31:0] cur_wdata;
  logic        cur_err;
  logic [IDX_W-1:0] cur_idx;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] align_word;
  logic [31:0] align_rdata;
  logic [3:0]  byte_en;
  logic [31:0] wdata_rep;

  logic [31:0] rdata_q;
  logic        err_q;

  assign accept          = bus.req_valid && bus.req_ready;
  assign bus.req_ready   = (state == IDLE);
  assign bus.resp_valid  = (state == RESP);
  assign bus.resp_rdata  = rdata_q;
  assign bus.resp_err    = err_q;

  // With zero wait states the access happens on the accept edge itself, so the
  // live request is used in IDLE and the latched copy otherwise.
  assign cur_we    = (state == IDLE) ? bus.req_we    : we_q;
  assign cur_addr  = (state == IDLE) ? bus.req_addr  : addr_q;
  assign cur_size  = (state == IDLE) ? bus.req_size  : size_q;
  assign cur_wdata = (state == IDLE) ? bus.req_wdata : wdata_q;
  assign cur_idx   = cur_addr[IDX_W+1:2];
  assign cur_err   = !size_is_legal(cur_size)
                   || addr_misaligned(cur_size, cur_addr[1:0])
                   || (cur_addr[31:2] >= DEPTH_LIM);

  assign commit     = !rst && (state_next == RESP) && (state != RESP);
  assign align_word = cur_we ? cur_wdata : mem[cur_idx];

  dmem_lane_align u_align (
    .addr_lo   (cur_addr[1:0]),
    .size      (cur_size),
    .word      (align_word),
    .rdata     (align_rdata),
    .byte_en   (byte_en),
    .wdata_rep (wdata_rep)
  );

  // State and wait-counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and wait-counter decode.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture every request field on the accepting edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= bus.req_we;
      addr_q  <= bus.req_addr;
      size_q  <= bus.req_size;
      wdata_q <= bus.req_wdata;
    end
  end

  // Response registers: loaded at the access edge, cleared once taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (commit) begin
      rdata_q <= (cur_we || cur_err) ? 32'd0 : align_rdata;
      err_q   <= cur_err;
    end else if (state == RESP && bus.resp_ready) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end
  end

  // Byte-enabled store into the backing array; errored stores never write.
  always_ff @(posedge clk) begin
    if (commit && cur_we && !cur_err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem[cur_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, giving the backing store size in 32-bit words (power of two, 4..4096).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, giving the number of wait-state cycles between request acceptance and response (0..15).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_size  input  mem_size_t  access size and signedness.
REQ-010 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 resp_valid  output  1  response is present.
REQ-012 resp_ready  input  1  initiator accepts the response.
REQ-013 resp_rdata  output  32  load data, right-aligned and extended; 0 for stores and errors.
REQ-014 resp_err  output  1  the request was misaligned, out of range, or had an illegal size.

Function
REQ-015 FSM states: IDLE, WAIT, RESP; req_ready = (state==IDLE); resp_valid = (state==RESP).
REQ-016 Handshake: a request is accepted when req_valid && req_ready; all request fields are latched on that edge.
REQ-017 Transition IDLE->WAIT on accept when WAIT_CYCLES>0 and the wait counter loads WAIT_CYCLES-1; transition IDLE->RESP on accept when WAIT_CYCLES==0.
REQ-018 In WAIT the counter decrements each cycle; transition WAIT->RESP on the cycle the counter equals 0.
REQ-019 Latency is accept edge to resp_valid high = WAIT_CYCLES+1 cycles.
REQ-020 In RESP, resp_valid, resp_rdata and resp_err SHALL hold stable until resp_ready; transition RESP->IDLE on resp_valid && resp_ready.
REQ-021 Only one transaction is outstanding; a new request is accepted no earlier than the cycle after response completion.
REQ-022 Error checks on the latched request: MEM_HALF/MEM_HALFU with addr[0]!=0 is an error; MEM_WORD with addr[1:0]!=0 is an error; word index addr[31:2] >= DEPTH_WORDS is an error; req_size encodings 5..7 are an error.
REQ-023 An errored store SHALL NOT modify memory; an errored access returns resp_rdata=0 and resp_err=1.
REQ-024 A store commits to memory on the WAIT/IDLE->RESP transition edge via byte enables: byte = lane addr[1:0]; half = lanes {addr[1],0} and {addr[1],1}; word = all four lanes. Other lanes are unchanged.
REQ-025 A load reads the word at the same edge; the selected byte/half is extracted from lane addr[1:0]; MEM_BYTE/MEM_HALF sign-extend; MEM_BYTEU/MEM_HALFU zero-extend; MEM_WORD passes the word through.
REQ-026 The load path SHALL observe stores from all previously completed transactions (no stale data).
REQ-027 req_addr bits above index range are checked, not truncated.

Reset
REQ-028 When rst is high at a clock edge: state=IDLE, counter=0, resp_valid=0, resp_err=0, resp_rdata=0; req_ready=1 on the first cycle after reset.
REQ-029 Memory contents are not reset.
REQ-030 Reset asserted in WAIT SHALL abort the transaction with no write; reset asserted in RESP SHALL drop the response (the write has already committed).

Structure
REQ-031 mem_size_t is shared from enums_pkg.
REQ-032 The state enum dmem_state_t (IDLE, WAIT, RESP) SHALL be added to enums_pkg.
REQ-033 Lane steering and extension SHALL be a combinational sub-module dmem_lane_align with inputs addr[1:0], size and word, and outputs rdata, byte enables and replicated wdata.
REQ-034 Storage SHALL be an inferred synchronous array of DEPTH_WORDS x 32.

Verification
REQ-035 Store MEM_WORD 0xDEADBEEF @0x10, then load MEM_WORD @0x10 -> rdata 0xDEADBEEF, err 0, each response 3 cycles after accept (WAIT_CYCLES=2).
REQ-036 After REQ-035: load MEM_BYTE @0x13 -> 0xFFFFFFDE; MEM_BYTEU @0x13 -> 0x000000DE; MEM_HALF @0x10 -> 0xFFFFBEEF; MEM_HALFU @0x12 -> 0x0000DEAD.
REQ-037 Store MEM_BYTE 0x12345678 @0x11, then load MEM_WORD @0x10 -> 0xDEAD78EF.
REQ-038 Store MEM_WORD @0x12 -> err 1, rdata 0; a subsequent load @0x10 returns unchanged data. Load @ (DEPTH_WORDS*4) -> err 1. Size encoding 6 -> err 1.
REQ-039 Hold resp_ready low for 5 cycles -> resp_valid, rdata and err stay stable and req_ready stays 0; request back-to-back on the cycle after completion -> accepted.
REQ-040 Assert rst during WAIT of a store of 0xAAAAAAAA @0x20 -> next cycle IDLE, resp_valid 0; a following load @0x20 returns the prior value.
